prio_arbiter: RTL and testbench

PRIO_ARBITER -- requirements
Module: prio_arbiter

---
 rtl/prio_arbiter_pkg.sv | 20 ++
 rtl/prio_pick.sv | 24 ++
 rtl/prio_arbiter.sv | 102 ++++++++++
 tb/tb_prio_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/prio_arbiter_pkg.sv
// Shared types and limits for the priority arbiter.
// Round-robin support is compiled in only when PRIO_ARBITER_RR_EN is defined.
package prio_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam int N_MIN = 2;
  localparam int N_MAX = 32;

  // (a + b) mod n for operands already in 0..n-1; avoids a divider for non-power-of-2 n.
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational highest-set-bit finder: returns the index of the top set bit
// of i_vec, with o_found low when the vector is empty.
module prio_pick #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] i_vec,
  output logic [W-1:0] o_idx,
  output logic         o_found
);

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i_vec[i]) begin
        o_idx   = W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_arbiter.sv
// N-channel arbiter with a registered one-hot grant held until ack.
// Fixed priority (top index wins) by default; PRIO_ARBITER_RR_EN adds round-robin via mode.
module prio_arbiter
  import prio_arbiter_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         ack,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_valid,
  output logic         z
);

  if (N < N_MIN || N > N_MAX) begin : g_bad_n
    $error("prio_arbiter: N out of range");
  end

  state_e         r_state;
  logic [N-1:0]   w_pick_vec;
  logic [W-1:0]   w_pick_idx;
  logic [W-1:0]   w_win_idx;
  logic           w_found;
  logic [N-1:0]   w_win_onehot;

`ifdef PRIO_ARBITER_RR_EN
  logic [W-1:0] r_ptr;

  // Rotate so channel ptr-1 lands on the top bit; ptr itself becomes the lowest priority.
  always_comb begin
    w_pick_vec = req;
    if (mode) begin
      for (int j = 0; j < N; j++) begin
        w_pick_vec[j] = req[wrap_add(j, int'(r_ptr), N)];
      end
    end
  end

  assign w_win_idx = mode ? W'(wrap_add(int'(w_pick_idx), int'(r_ptr), N)) : w_pick_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (r_state == IDLE && w_found) begin
      r_ptr <= w_win_idx;
    end
  end
`else
  logic w_unused_mode;
  assign w_unused_mode = mode;
  assign w_pick_vec    = req;
  assign w_win_idx     = w_pick_idx;
`endif

  prio_pick #(.N(N)) u_pick (
    .i_vec   (w_pick_vec),
    .o_idx   (w_pick_idx),
    .o_found (w_found)
  );

  assign w_win_onehot = {{(N-1){1'b0}}, 1'b1} << w_win_idx;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      z         <= 1'b1;
    end else begin
      z <= (req == '0);
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state   <= GRANT;
            gnt       <= w_win_onehot;
            gnt_idx   <= w_win_idx;
            gnt_valid <= 1'b1;
          end else begin
            gnt       <= '0;
            gnt_valid <= 1'b0;
          end
        end
        GRANT: begin
          if (ack) begin
            r_state   <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prio_arbiter.sv
// Self-checking bench for prio_arbiter: behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_prio_arbiter;

  localparam int N = 8;
  localparam int W = $clog2(N);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic         mode = 1'b0;
  logic         ack = 1'b0;
  logic [N-1:0] gnt;
  logic [W-1:0] gnt_idx;
  logic         gnt_valid;
  logic         z;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  prio_arbiter #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .mode      (mode),
    .ack       (ack),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .z         (z)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: busy flag, granted index, last-winner pointer, registered zero flag.
  bit m_busy = 1'b0;
  int m_idx = 0;
  int m_ptr = 0;
  bit m_z = 1'b1;

  function automatic int pick(input logic [N-1:0] r, input logic md, input int ptr);
    bit rr;
    rr = 1'b0;
`ifdef PRIO_ARBITER_RR_EN
    rr = md;
`endif
    if (rr) begin
      for (int s = 1; s <= N; s++) begin
        int c;
        c = (ptr - s + N) % N;
        if (r[c]) return c;
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (r[i]) return i;
    end
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_idx  = 0;
      m_ptr  = 0;
      m_z    = 1'b1;
    end else begin
      m_z = (req == '0);
      if (m_busy) begin
        if (ack) m_busy = 1'b0;
      end else if (req != '0) begin
        m_idx  = pick(req, mode, m_ptr);
        m_ptr  = m_idx;
        m_busy = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [N-1:0] exp_gnt;
      exp_gnt = '0;
      if (m_busy) exp_gnt[m_idx] = 1'b1;
      check("gnt", 32'(gnt), 32'(exp_gnt));
      check("gnt_idx", 32'(gnt_idx), 32'(m_idx));
      check("gnt_valid", 32'(gnt_valid), 32'(m_busy));
      check("z", 32'(z), 32'(m_z));
    end
  end

  // Outputs reflect the edge just taken; inputs driven here are sampled at the next edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    tick();
    tick();
    cmp_en = 1'b1;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_idx", 32'(gnt_idx), 32'h0);
    check("rst_valid", 32'(gnt_valid), 32'h0);
    check("rst_z", 32'(z), 32'h1);

    rst_n = 1'b1;
    req = 8'b0010_0110;
    tick();
    check("fixed_gnt", 32'(gnt), 32'h20);
    check("fixed_idx", 32'(gnt_idx), 32'd5);
    check("fixed_valid", 32'(gnt_valid), 32'h1);
    req = 8'h03;
    tick();
    tick();
    check("hold_gnt", 32'(gnt), 32'h20);
    check("hold_idx", 32'(gnt_idx), 32'd5);
    ack = 1'b1;
    tick();
    check("ack_valid", 32'(gnt_valid), 32'h0);
    check("ack_gnt", 32'(gnt), 32'h0);
    ack = 1'b0;

    req = 8'h08;
    tick();
    check("idx3", 32'(gnt_idx), 32'd3);
    req = 8'h00;
    tick();
    check("drop_idx", 32'(gnt_idx), 32'd3);
    check("drop_valid", 32'(gnt_valid), 32'h1);
    check("drop_z", 32'(z), 32'h1);
    ack = 1'b1;
    tick();
    check("drop_ack_gnt", 32'(gnt), 32'h0);
    check("drop_ack_valid", 32'(gnt_valid), 32'h0);
    tick();
    check("idle_ack_valid", 32'(gnt_valid), 32'h0);
    check("idle_ack_idx", 32'(gnt_idx), 32'd3);
    req = 8'h01;
    tick();
    check("ack_req_idx", 32'(gnt_idx), 32'd0);
    check("ack_req_gnt", 32'(gnt), 32'h01);
    ack = 1'b0;
    req = 8'h00;
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;

    req = 8'h80;
    mode = 1'b1;
    tick();
    check("pre_rst_gnt", 32'(gnt), 32'h80);
    rst_n = 1'b0;
    #1;
    check("async_rst_gnt", 32'(gnt), 32'h0);
    check("async_rst_valid", 32'(gnt_valid), 32'h0);
    check("async_rst_z", 32'(z), 32'h1);
    tick();
    rst_n = 1'b1;
    req = 8'hFF;
    mode = 1'b1;
    tick();
    check("post_rst_idx", 32'(gnt_idx), 32'd7);
    ack = 1'b1;
    for (int k = 0; k < 8; k++) begin
      int exp_idx;
`ifdef PRIO_ARBITER_RR_EN
      exp_idx = (6 - k + 8) % 8;
`else
      exp_idx = 7;
`endif
      tick();
      tick();
      check($sformatf("seq_idx_%0d", k), 32'(gnt_idx), 32'(exp_idx));
    end
    ack = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 99) == 0) rst_n = 1'b0;
      req  = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      mode = 1'($urandom_range(0, 1));
      ack  = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
